// File: rtl/pwm_pkg.sv
// pwm_pkg: shared PWM constants, FSM state and duty types, channel output mux
package pwm_pkg;

    localparam int PWM_STEPS = 255;

    typedef enum logic {IDLE, RUN} state_t;

    typedef logic [7:0] duty_t;

    function automatic logic [15:0] pwm_mux(
        input logic [15:0] en_out,
        input logic [15:0] en_pwm,
        input logic        level
    );
        return en_out & (~en_pwm | {16{level}});
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// pwm_prescaler: one-clk tick every PRESCALE cycles, held at zero while clear is high
module pwm_prescaler #(
    parameter int unsigned PRESCALE = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(PRESCALE - 1);

    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        tick  = !clear && cnt_q == LAST;
        cnt_d = clear || tick ? 16'd0 : cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;

endmodule

// File: rtl/pwm_output_stage.sv
// pwm_output_stage: 16 registered channels, each off, static high or following a shared PWM level
module pwm_output_stage
    import pwm_pkg::*;
#(
    parameter int unsigned PRESCALE = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);

    logic [15:0] en_out, en_pwm, out_d, out_q;
    logic        active, presc_clear, tick, start, wrap, pwm_level;
    logic        period_start_d, period_start_q;
    state_t      state_d, state_q;
    duty_t       counter_d, counter_q, duty_shadow_d, duty_shadow_q;

    pwm_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (presc_clear),
        .tick  (tick)
    );

    // Register inputs share clk with the SPI block, so they are used unsynchronised
    always_comb begin
        en_out         = {en_reg_out_15_8, en_reg_out_7_0};
        en_pwm         = {en_reg_pwm_15_8, en_reg_pwm_7_0};
        active         = |(en_out & en_pwm);
        state_d        = active ? RUN : IDLE;
        presc_clear    = state_q == IDLE || !active;
        start          = state_q == IDLE && active;
        wrap           = tick && counter_q == duty_t'(PWM_STEPS - 1);
        counter_d      = presc_clear || wrap ? '0 : counter_q + duty_t'(tick);
        duty_shadow_d  = start || wrap ? pwm_duty_cycle : duty_shadow_q;
        period_start_d = start || wrap;
        // counter never exceeds 254, so duty 255 stays high through the wrap
        pwm_level      = state_q == RUN && counter_q < duty_shadow_q;
        out_d          = pwm_mux(en_out, en_pwm, pwm_level);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            counter_q      <= '0;
            duty_shadow_q  <= '0;
            period_start_q <= 1'b0;
            out_q          <= '0;
        end else begin
            state_q        <= state_d;
            counter_q      <= counter_d;
            duty_shadow_q  <= duty_shadow_d;
            period_start_q <= period_start_d;
            out_q          <= out_d;
        end
    end

    assign out          = out_q;
    assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_output_stage.sv
// tb_pwm_output_stage: scoreboard bench driving PRESCALE=1 and default PRESCALE=3 instances in lockstep
module tb_pwm_output_stage;

    typedef struct {
        string       tag;
        logic [15:0] o1;
        logic [15:0] o3;
        logic        p1;
        logic        p3;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  eo_lo = '0, eo_hi = '0, ep_lo = '0, ep_hi = '0, duty = '0;
    logic [15:0] out1, out3;
    logic        ps1, ps3;

    exp_t        sb[$];
    exp_t        mon_e;
    int          vectors = 0, miscompares = 0;
    int          hi1 = 0, hi3 = 0, nps1 = 0, nps3 = 0;
    string       tag = "reset";

    bit          run[2];
    int          k[2];
    logic [7:0]  dsh[2];
    int          per[2] = '{1, 3};

    always #5 clk = ~clk;

    pwm_output_stage #(.PRESCALE(1)) dut1 (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (eo_lo),
        .en_reg_out_15_8 (eo_hi),
        .en_reg_pwm_7_0  (ep_lo),
        .en_reg_pwm_15_8 (ep_hi),
        .pwm_duty_cycle  (duty),
        .out             (out1),
        .period_start    (ps1)
    );

    pwm_output_stage dut3 (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (eo_lo),
        .en_reg_out_15_8 (eo_hi),
        .en_reg_pwm_7_0  (ep_lo),
        .en_reg_pwm_15_8 (ep_hi),
        .pwm_duty_cycle  (duty),
        .out             (out3),
        .period_start    (ps3)
    );

    task automatic chk(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic clr();
        hi1 = 0; hi3 = 0; nps1 = 0; nps3 = 0;
    endtask

    // Expected value after the coming edge, from cycles elapsed since the period train began
    task automatic step(input int n);
        exp_t        e;
        logic [15:0] eo, ep;
        logic [15:0] o[2];
        logic        s[2];
        logic        act, lvl;
        for (int c = 0; c < n; c++) begin
            eo  = {eo_hi, eo_lo};
            ep  = {ep_hi, ep_lo};
            act = |(eo & ep);
            for (int d = 0; d < 2; d++) begin
                lvl  = run[d] && (((k[d] / per[d]) % 255) < int'(dsh[d]));
                o[d] = rst_n ? ((eo & ~ep) | (eo & ep & {16{lvl}})) : 16'h0000;
                s[d] = rst_n && act && (!run[d] || (k[d] + 1) % (255 * per[d]) == 0);
                if (!rst_n || !act) run[d] = 1'b0;
                else if (!run[d]) begin
                    run[d] = 1'b1;
                    k[d]   = 0;
                    dsh[d] = duty;
                end else begin
                    k[d]++;
                    if (k[d] % (255 * per[d]) == 0) dsh[d] = duty;
                end
            end
            e.tag = tag;
            e.o1  = o[0];
            e.p1  = s[0];
            e.o3  = o[1];
            e.p3  = s[1];
            sb.push_back(e);
            @(negedge clk);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            vectors++;
            if (out1 !== mon_e.o1 || ps1 !== mon_e.p1 || out3 !== mon_e.o3 || ps3 !== mon_e.p3) begin
                miscompares++;
                $display("FAIL %s @%0t: out1=%h ps1=%b out3=%h ps3=%b, expected out1=%h ps1=%b out3=%h ps3=%b",
                         mon_e.tag, $time, out1, ps1, out3, ps3, mon_e.o1, mon_e.p1, mon_e.o3, mon_e.p3);
            end
            hi1  += int'(out1[0] === 1'b1);
            hi3  += int'(out3[0] === 1'b1);
            nps1 += int'(ps1 === 1'b1);
            nps3 += int'(ps3 === 1'b1);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not complete, %0d vectors pending", sb.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk);
        chk("reset_out1", int'(out1), 0);
        chk("reset_out3", int'(out3), 0);
        chk("reset_ps1", int'(ps1), 0);
        chk("reset_ps3", int'(ps3), 0);
        step(2);
        rst_n = 1'b1;

        tag = "static";
        clr();
        eo_lo = 8'h01;
        step(6);
        chk("static_high", hi1, 6);
        chk("static_no_period", nps1 + nps3, 0);

        // Duty changes issued at the start of a 255-clk block land in the following period
        tag = "duty";
        eo_lo = 8'hFF; ep_lo = 8'h01; duty = 8'h80;
        step(1);
        clr(); step(255);
        chk("duty80_p0_high", hi1, 128);
        chk("duty80_p0_starts", nps1, 1);
        duty = 8'h00;
        clr(); step(255);
        chk("duty80_p1_high", hi1, 128);
        tag = "boundary";
        duty = 8'hFF;
        clr(); step(255);
        chk("duty00_high", hi1, 0);
        chk("duty00_starts", nps1, 1);
        clr(); step(510);
        duty = 8'h40;
        step(255);
        chk("dutyFF_high", hi1, 765);
        chk("dutyFF_wraps", nps1, 3);

        tag = "shadow";
        clr(); step(10);
        duty = 8'hC0;
        step(245);
        chk("shadow_current", hi1, 64);
        clr(); step(255);
        chk("shadow_next", hi1, 192);

        tag = "prescale";
        eo_lo = 8'h00; ep_lo = 8'h00;
        step(2);
        eo_lo = 8'h01; ep_lo = 8'h01; duty = 8'h01;
        step(1);
        clr(); step(765);
        chk("prescale_high", hi3, 3);
        chk("prescale_starts", nps3, 1);
        ep_lo = 8'h00;
        clr(); step(10);
        chk("prescale_idle_starts", nps3, 0);
        chk("prescale_idle_static", hi3, 10);

        tag = "reset_mid";
        eo_lo = 8'hFF; ep_lo = 8'hFF; duty = 8'h80;
        step(51);
        rst_n = 1'b0;
        #1;
        chk("async_rst_out1", int'(out1), 0);
        chk("async_rst_out3", int'(out3), 0);
        chk("async_rst_ps1", int'(ps1), 0);
        chk("async_rst_ps3", int'(ps3), 0);
        eo_lo = 8'h00; ep_lo = 8'h00;
        step(3);
        rst_n = 1'b1;
        clr(); step(5);
        chk("post_rst_quiet", hi1 + hi3 + nps1 + nps3, 0);
        eo_lo = 8'h01; ep_lo = 8'h01;
        clr(); step(3);
        chk("post_rst_start1", nps1, 1);
        chk("post_rst_start3", nps3, 1);

        chk("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
